// File: rtl/jtopll_pkg.sv
// rtl/jtopll_pkg.sv - OPLL write-sequencer address map, state encoding and strobe bundle
package jtopll_pkg;

  localparam logic [7:0] UINST_LO  = 8'h00;
  localparam logic [7:0] UINST_HI  = 8'h07;
  localparam logic [7:0] RHY_ADDR  = 8'h0E;
  localparam logic [7:0] FNLO_BASE = 8'h10;
  localparam logic [7:0] FNHI_BASE = 8'h20;
  localparam logic [7:0] INST_BASE = 8'h30;
  localparam logic [3:0] NCH       = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AWAIT = 2'd1,
    ST_DPEND = 2'd2,
    ST_DWAIT = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic user;
    logic rhy;
    logic fnlo;
    logic fnhi;
    logic inst;
  } wr_strobe_t;

endpackage

// File: rtl/jtopll_wr_ctrl.sv
// rtl/jtopll_wr_ctrl.sv - OPLL CPU write sequencer: address/data latching, register strobes, busy windows
// Busy windows after each write are built only with JTOPLL_BUSY_EN defined.
module jtopll_wr_ctrl
  import jtopll_pkg::*;
#(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int CNTW      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic [3:0] up_ch,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_rhy,
  output logic       up_user,
  output logic [2:0] up_uaddr,
  output logic [7:0] dout
);

  if ((2 ** CNTW) <= ADDR_WAIT || (2 ** CNTW) <= DATA_WAIT) begin : g_cntw_too_small
    $error("jtopll_wr_ctrl: CNTW too narrow for the busy windows");
  end

  wr_state_e  state_q, state_d;
  logic [7:0] areg_q, areg_d;
  logic [7:0] dout_q, dout_d;
  logic [3:0] ch_q, ch_d;
  logic [2:0] uaddr_q, uaddr_d;
  wr_strobe_t stb_q, stb_d;
  logic       wr_n_q;
  logic       wr_ev;
  wr_strobe_t dec;

`ifdef JTOPLL_BUSY_EN
  localparam logic [CNTW-1:0] ADDR_LOAD = CNTW'(ADDR_WAIT);
  localparam logic [CNTW-1:0] DATA_LOAD = CNTW'(DATA_WAIT);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  function automatic logic in_bank(input logic [7:0] a, input logic [7:0] base);
    return (a[7:4] == base[7:4]) && (a[3:0] < NCH);
  endfunction

  function automatic wr_strobe_t decode(input logic [7:0] a);
    wr_strobe_t d;
    d      = '0;
    // User-instrument block is a power-of-two aligned range
    d.user = ((a & ~(UINST_HI - UINST_LO)) == UINST_LO);
    d.rhy  = (a == RHY_ADDR);
    d.fnlo = in_bank(a, FNLO_BASE);
    d.fnhi = in_bank(a, FNHI_BASE);
    d.inst = in_bank(a, INST_BASE);
    return d;
  endfunction

  assign wr_ev = wr_n_q & ~wr_n;
  assign dec   = decode(areg_q);

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    uaddr_d = uaddr_q;
    stb_d   = stb_q;
`ifdef JTOPLL_BUSY_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr_ev) begin
          if (!addr) begin
            areg_d = din;
`ifdef JTOPLL_BUSY_EN
            cnt_d   = ADDR_LOAD;
            state_d = ST_AWAIT;
`endif
          end else begin
            dout_d  = din;
            stb_d   = dec;
            state_d = ST_DPEND;
            if (dec.fnlo || dec.fnhi || dec.inst) ch_d = areg_q[3:0];
            if (dec.user) uaddr_d = areg_q[2:0];
          end
        end
      end
      ST_DPEND: begin
        // The register file samples the strobe on this cen edge, so drop it here
        if (cen) begin
          stb_d = '0;
`ifdef JTOPLL_BUSY_EN
          cnt_d   = DATA_LOAD;
          state_d = ST_DWAIT;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef JTOPLL_BUSY_EN
      ST_AWAIT, ST_DWAIT: begin
        if (cen) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n_q  <= 1'b0;
      state_q <= ST_IDLE;
      areg_q  <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      uaddr_q <= '0;
      stb_q   <= '0;
    end else begin
      wr_n_q  <= wr_n;
      state_q <= state_d;
      areg_q  <= areg_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      uaddr_q <= uaddr_d;
      stb_q   <= stb_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign up_ch     = ch_q;
  assign up_uaddr  = uaddr_q;
  assign dout      = dout_q;
  assign up_user   = stb_q.user;
  assign up_rhy    = stb_q.rhy;
  assign up_fnumlo = stb_q.fnlo;
  assign up_fnumhi = stb_q.fnhi;
  assign up_inst   = stb_q.inst;

endmodule
